// File: rtl/dnoc_l2_rd_arb.sv
// Arbitrates the single L2 dmem read port between the core-read (m0) and NoC-read (m1) engines.
// Latency: grant 1 cycle after req from IDLE; read data/valid LAT cycles after an honoured rd_en.
// Backpressure: none on the return path; the losing requester simply waits for gnt (one IDLE gap between owners).
module dnoc_l2_rd_arb #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 256,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  output logic              m0_gnt,
  input  logic              m0_rd_en,
  input  logic [ADDR_W-1:0] m0_rd_addr,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_rd_valid,
  input  logic              m1_req,
  output logic              m1_gnt,
  input  logic              m1_rd_en,
  input  logic [ADDR_W-1:0] m1_rd_addr,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_rd_valid,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic              arb_owner,
  output logic              arb_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_rr_pri;      // 0: m0 wins the next contended decision
  logic   w_rr_pri_nxt;
  logic   r_owner;
  logic   r_err;
  logic   w_illegal;

  // Return pipeline: one {valid, id} entry per cycle of SRAM latency.
  logic [LAT-1:0] r_ret_vld;
  logic [LAT-1:0] r_ret_id;

  // Grants come straight from registered state so they are glitch-free.
  assign m0_gnt = (r_state == OWN0);
  assign m1_gnt = (r_state == OWN1);

  // Only the owner's strobe reaches the SRAM; the address bus is parked at 0 when nobody owns it.
  assign sram_rd_en   = (m0_gnt & m0_rd_en) | (m1_gnt & m1_rd_en);
  assign sram_rd_addr = m0_gnt ? m0_rd_addr : (m1_gnt ? m1_rd_addr : '0);

  // Data bus is shared; the valids steer it to whoever issued the read, not the current owner.
  assign m0_rd_data  = sram_rd_data;
  assign m1_rd_data  = sram_rd_data;
  assign m0_rd_valid = r_ret_vld[LAT-1] & ~r_ret_id[LAT-1];
  assign m1_rd_valid = r_ret_vld[LAT-1] &  r_ret_id[LAT-1];

  assign w_illegal = (m0_rd_en & ~m0_gnt) | (m1_rd_en & ~m1_gnt);
  assign arb_owner = r_owner;
  assign arb_err   = r_err;

  // Next-state: grant whole bursts, round-robin only when both ask in IDLE, release via IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_rr_pri_nxt = r_rr_pri;
    case (r_state)
      IDLE: begin
        if (m0_req && m1_req) begin
          w_state_nxt  = r_rr_pri ? OWN1 : OWN0;
          w_rr_pri_nxt = ~r_rr_pri;
        end else if (m0_req) begin
          w_state_nxt = OWN0;
        end else if (m1_req) begin
          w_state_nxt = OWN1;
        end
      end
      OWN0:    if (!m0_req) w_state_nxt = IDLE;
      OWN1:    if (!m1_req) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, fairness pointer, last-owner and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rr_pri <= 1'b0;
      r_owner  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_pri <= w_rr_pri_nxt;
      if (w_state_nxt == OWN0) begin
        r_owner <= 1'b0;
      end else if (w_state_nxt == OWN1) begin
        r_owner <= 1'b1;
      end
      if (w_illegal) begin
        r_err <= 1'b1;
      end
    end
  end

  generate
    if (LAT == 1) begin : g_ret_lat1
      // Single-stage return tag: issuer id captured alongside the strobe.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ret_vld <= '0;
          r_ret_id  <= '0;
        end else begin
          r_ret_vld <= sram_rd_en;
          r_ret_id  <= m1_gnt;
        end
      end
    end else begin : g_ret_latn
      // Multi-stage return tag shift register, oldest entry at the top bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ret_vld <= '0;
          r_ret_id  <= '0;
        end else begin
          r_ret_vld <= {r_ret_vld[LAT-2:0], sram_rd_en};
          r_ret_id  <= {r_ret_id[LAT-2:0], m1_gnt};
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_dnoc_l2_rd_arb.sv
// Directed bench for dnoc_l2_rd_arb: a LAT=1 and a LAT=2 instance share one stimulus.
// Each instance has its own behavioural SRAM returning a pattern derived from the address.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_dnoc_l2_rd_arb;

  logic clk;
  logic rst_n;
  logic m0_req, m0_rd_en, m1_req, m1_rd_en;
  logic [12:0] m0_rd_addr, m1_rd_addr;

  logic d1_g0, d1_g1, d1_en, d1_v0, d1_v1, d1_own, d1_err;
  logic [12:0] d1_sa;
  logic [255:0] d1_rd0, d1_rd1, d1_sd;
  logic d2_g0, d2_g1, d2_en, d2_v0, d2_v1, d2_own, d2_err;
  logic [12:0] d2_sa;
  logic [255:0] d2_rd0, d2_rd1, d2_sd, d2_q1;

  int n_chk = 0;
  int n_pass = 0;

  dnoc_l2_rd_arb #(.ADDR_W(13), .DATA_W(256), .LAT(1)) d1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_gnt(d1_g0), .m0_rd_en(m0_rd_en), .m0_rd_addr(m0_rd_addr),
    .m0_rd_data(d1_rd0), .m0_rd_valid(d1_v0),
    .m1_req(m1_req), .m1_gnt(d1_g1), .m1_rd_en(m1_rd_en), .m1_rd_addr(m1_rd_addr),
    .m1_rd_data(d1_rd1), .m1_rd_valid(d1_v1),
    .sram_rd_en(d1_en), .sram_rd_addr(d1_sa), .sram_rd_data(d1_sd),
    .arb_owner(d1_own), .arb_err(d1_err)
  );

  dnoc_l2_rd_arb #(.ADDR_W(13), .DATA_W(256), .LAT(2)) d2 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_gnt(d2_g0), .m0_rd_en(m0_rd_en), .m0_rd_addr(m0_rd_addr),
    .m0_rd_data(d2_rd0), .m0_rd_valid(d2_v0),
    .m1_req(m1_req), .m1_gnt(d2_g1), .m1_rd_en(m1_rd_en), .m1_rd_addr(m1_rd_addr),
    .m1_rd_data(d2_rd1), .m1_rd_valid(d2_v1),
    .sram_rd_en(d2_en), .sram_rd_addr(d2_sa), .sram_rd_data(d2_sd),
    .arb_owner(d2_own), .arb_err(d2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input logic [12:0] a);
    pat = {16{3'b101, a}};
  endfunction

  // Behavioural SRAMs: 1-cycle and 2-cycle read latency.
  always @(posedge clk) if (d1_en) d1_sd <= pat(d1_sa);
  always @(posedge clk) begin
    if (d2_en) d2_q1 <= pat(d2_sa);
    d2_sd <= d2_q1;
  end

  wire [19:0] act1 = {d1_g0, d1_g1, d1_en, d1_sa, d1_v0, d1_v1, d1_own, d1_err};
  wire [19:0] act2 = {d2_g0, d2_g1, d2_en, d2_sa, d2_v0, d2_v1, d2_own, d2_err};

  typedef struct {
    logic m0r, m0e; logic [12:0] m0a;
    logic m1r, m1e; logic [12:0] m1a;
    logic [19:0] exp;   // {g0, g1, sram_en, sram_addr, v0, v1, owner, err}
    logic [12:0] da;    // address whose data should be on the return bus
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input int m0r, m0e, m0a, m1r, m1e, m1a,
                              g0, g1, en, sa, v0, v1, own, err, da);
    vec_t v;
    v.m0r = m0r[0]; v.m0e = m0e[0]; v.m0a = m0a[12:0];
    v.m1r = m1r[0]; v.m1e = m1e[0]; v.m1a = m1a[12:0];
    v.exp = {g0[0], g1[0], en[0], sa[12:0], v0[0], v1[0], own[0], err[0]};
    v.da  = da[12:0];
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic chk_d(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc(input int a0r, a0e, a0a, a1r, a1e, a1a);
    @(posedge clk); #1;
    m0_req = a0r[0]; m0_rd_en = a0e[0]; m0_rd_addr = a0a[12:0];
    m1_req = a1r[0]; m1_rd_en = a1e[0]; m1_rd_addr = a1a[12:0];
    @(negedge clk);
  endtask

  task automatic do_reset();
    m0_req = 0; m0_rd_en = 0; m0_rd_addr = '0;
    m1_req = 0; m1_rd_en = 0; m1_rd_addr = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Burst, contention alternation, address parking and illegal strobe, LAT=1 view.
    //            m0r m0e m0a    m1r m1e m1a    g0 g1 en sa     v0 v1 own err da
    tbl[0]  = mk(1, 0, 'h000, 0, 0, 'h000, 0, 0, 0, 'h000, 0, 0, 0, 0, 'h000);
    tbl[1]  = mk(1, 1, 'h010, 0, 0, 'h000, 1, 0, 1, 'h010, 0, 0, 0, 0, 'h000);
    tbl[2]  = mk(1, 1, 'h011, 0, 0, 'h000, 1, 0, 1, 'h011, 1, 0, 0, 0, 'h010);
    tbl[3]  = mk(1, 1, 'h012, 0, 0, 'h000, 1, 0, 1, 'h012, 1, 0, 0, 0, 'h011);
    tbl[4]  = mk(1, 1, 'h013, 0, 0, 'h000, 1, 0, 1, 'h013, 1, 0, 0, 0, 'h012);
    tbl[5]  = mk(0, 0, 'h000, 0, 0, 'h000, 1, 0, 0, 'h000, 1, 0, 0, 0, 'h013);
    tbl[6]  = mk(0, 0, 'h055, 0, 0, 'h000, 0, 0, 0, 'h000, 0, 0, 0, 0, 'h000);
    tbl[7]  = mk(1, 0, 'h000, 1, 0, 'h000, 0, 0, 0, 'h000, 0, 0, 0, 0, 'h000);
    tbl[8]  = mk(1, 1, 'h020, 1, 0, 'h000, 1, 0, 1, 'h020, 0, 0, 0, 0, 'h000);
    tbl[9]  = mk(0, 0, 'h077, 1, 0, 'h000, 1, 0, 0, 'h077, 1, 0, 0, 0, 'h020);
    tbl[10] = mk(0, 0, 'h000, 1, 0, 'h000, 0, 0, 0, 'h000, 0, 0, 0, 0, 'h000);
    tbl[11] = mk(0, 0, 'h000, 1, 1, 'h030, 0, 1, 1, 'h030, 0, 0, 1, 0, 'h000);
    tbl[12] = mk(1, 0, 'h000, 0, 0, 'h000, 0, 1, 0, 'h000, 0, 1, 1, 0, 'h030);
    tbl[13] = mk(1, 0, 'h000, 1, 0, 'h000, 0, 0, 0, 'h000, 0, 0, 1, 0, 'h000);
    tbl[14] = mk(1, 0, 'h000, 1, 1, 'h031, 0, 1, 1, 'h031, 0, 0, 1, 0, 'h000);
    tbl[15] = mk(1, 0, 'h000, 0, 0, 'h000, 0, 1, 0, 'h000, 0, 1, 1, 0, 'h031);
    tbl[16] = mk(1, 0, 'h000, 1, 0, 'h000, 0, 0, 0, 'h000, 0, 0, 1, 0, 'h000);
    tbl[17] = mk(1, 1, 'h021, 1, 1, 'h0AA, 1, 0, 1, 'h021, 0, 0, 0, 0, 'h000);
    tbl[18] = mk(0, 0, 'h000, 0, 0, 'h000, 1, 0, 0, 'h000, 1, 0, 0, 1, 'h021);
    tbl[19] = mk(0, 0, 'h000, 0, 0, 'h000, 0, 0, 0, 'h000, 0, 0, 0, 1, 'h000);
    tbl[20] = mk(0, 0, 'h000, 0, 0, 'h000, 0, 0, 0, 'h000, 0, 0, 0, 1, 'h000);

    m0_req = 0; m0_rd_en = 0; m0_rd_addr = '0;
    m1_req = 0; m1_rd_en = 0; m1_rd_addr = '0;
    rst_n = 1'b0;
    #3;
    chk("reset_d1", 64'(act1), 64'd0);
    chk("reset_d2", 64'(act2), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      cyc(int'(tbl[i].m0r), int'(tbl[i].m0e), int'(tbl[i].m0a),
          int'(tbl[i].m1r), int'(tbl[i].m1e), int'(tbl[i].m1a));
      chk($sformatf("vec%0d", i), 64'(act1), 64'(tbl[i].exp));
      if (tbl[i].exp[3]) chk_d($sformatf("vec%0d_m0_data", i), d1_rd0, pat(tbl[i].da));
      if (tbl[i].exp[2]) chk_d($sformatf("vec%0d_m1_data", i), d1_rd1, pat(tbl[i].da));
    end

    // In-flight handoff at LAT=2: m1's last read returns to m1 after m0 owns the port.
    do_reset();
    cyc(0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 1, 'h1FFF);
    chk("hoff_m1_gnt", 64'({d2_g1, d2_en, d2_sa}), 64'({1'b1, 1'b1, 13'h1FFF}));
    cyc(1, 0, 0, 0, 0, 0);
    chk("hoff_idle_d2", 64'({d2_g0, d2_g1, d2_v0, d2_v1}), 64'd0);
    cyc(1, 1, 'h005, 0, 0, 0);
    chk("hoff_ret_d2", 64'({d2_g0, d2_v0, d2_v1}), 64'({1'b1, 1'b0, 1'b1}));
    chk_d("hoff_ret_data", d2_rd1, pat(13'h1FFF));
    cyc(1, 0, 0, 0, 0, 0);
    chk("hoff_gap_d2", 64'({d2_v0, d2_v1}), 64'd0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hoff_m0_ret_d2", 64'({d2_v0, d2_v1}), 64'({1'b1, 1'b0}));
    chk_d("hoff_m0_data", d2_rd0, pat(13'h005));

    // Reset in the middle of a burst, after a contended grant moved the fairness pointer.
    do_reset();
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 1, 'h040, 0, 0, 0);
    cyc(1, 1, 'h041, 0, 0, 0);
    cyc(1, 1, 'h042, 0, 0, 0);
    chk("rstmid_pre", 64'({d1_g0, d1_en, d1_v0}), 64'(3'b111));
    rst_n = 1'b0;
    #1;
    chk("rstmid_d1", 64'(act1), 64'd0);
    chk("rstmid_d2", 64'(act2), 64'd0);
    m0_req = 0; m0_rd_en = 0; m0_rd_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      chk($sformatf("rstmid_quiet%0d", k),
          64'({d1_g0, d1_g1, d1_v0, d1_v1, d2_v0, d2_v1}), 64'd0);
    end
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("rstmid_rrpri", 64'({d1_g0, d1_g1}), 64'({1'b1, 1'b0}));

    // Uncontended m1 bursts leave the fairness pointer at m0.
    do_reset();
    for (int b = 0; b < 3; b++) begin
      cyc(0, 0, 0, 1, 0, 0);
      chk($sformatf("unc%0d_idle", b), 64'({d1_g0, d1_g1}), 64'd0);
      cyc(0, 0, 0, 1, 1, 'h100 + b);
      chk($sformatf("unc%0d_gnt", b), 64'({d1_g0, d1_g1, d1_sa}), 64'({1'b0, 1'b1, 13'(32'h100 + b)}));
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk($sformatf("unc%0d_rel", b), 64'({d1_g1, d1_own}), 64'({1'b0, 1'b1}));
    end
    cyc(1, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk("unc_contend", 64'({d1_g0, d1_g1, d1_own}), 64'({1'b1, 1'b0, 1'b0}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
